// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: control/address from the master, registered
// one-hot select plus strobes back from the decoder.
interface decoder_scan_if #(
  parameter int AW = 2
);
  localparam int OW = 2 ** AW;

  logic          en;
  logic          mode;
  logic [AW-1:0] a_in;
  logic          a_valid;
  logic [OW-1:0] y;
  logic [AW-1:0] y_idx;
  logic          y_valid;
  logic          wrap;

  modport master (
    output en, mode, a_in, a_valid,
    input  y, y_idx, y_valid, wrap
  );

  modport slave (
    input  en, mode, a_in, a_valid,
    output y, y_idx, y_valid, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with enable, valid strobe and an
// autonomous scan mode that walks the one-hot output at SCAN_DIV cycles/step.
module decoder_scan #(
  parameter int AW       = 2,
  parameter int SCAN_DIV = 4
) (
  input logic           clk,
  input logic           rst_n,
  decoder_scan_if.slave bus
);
  localparam int OW = 2 ** AW;
  localparam int DW = 16;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(OW - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] y_q, y_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] div_q, div_d;

  function automatic logic [OW-1:0] onehot(input logic [AW-1:0] idx);
    onehot = OW'(1) << idx;
  endfunction

  // Next-state logic; priority is en, then mode change, then a_valid/divider step.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    div_d   = div_q;
    if (!bus.en) begin
      state_d = ST_IDLE;
      y_d     = {OW{1'b0}};
      idx_d   = {AW{1'b0}};
      div_d   = {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d = {AW{1'b0}};
          div_d = {DW{1'b0}};
          if (bus.mode) begin
            state_d = ST_SCAN;
            y_d     = onehot({AW{1'b0}});
            valid_d = 1'b1;
          end else begin
            state_d = ST_DIRECT;
            y_d     = {OW{1'b0}};
          end
        end
        ST_DIRECT: begin
          if (bus.mode) begin
            // Scan always restarts at index 0; a_valid this cycle is dropped.
            state_d = ST_SCAN;
            y_d     = onehot({AW{1'b0}});
            idx_d   = {AW{1'b0}};
            valid_d = 1'b1;
            div_d   = {DW{1'b0}};
          end else if (bus.a_valid) begin
            y_d     = onehot(bus.a_in);
            idx_d   = bus.a_in;
            valid_d = 1'b1;
          end else begin
            y_d     = y_q;
          end
        end
        ST_SCAN: begin
          if (!bus.mode) begin
            state_d = ST_DIRECT;
            div_d   = {DW{1'b0}};
          end else if (div_q == DIV_LAST) begin
            div_d   = {DW{1'b0}};
            idx_d   = idx_q + AW'(1);
            y_d     = onehot(idx_q + AW'(1));
            valid_d = 1'b1;
            wrap_d  = (idx_q == IDX_LAST);
          end else begin
            div_d   = div_q + DW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          y_d     = {OW{1'b0}};
          idx_d   = {AW{1'b0}};
          div_d   = {DW{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= {OW{1'b0}};
      idx_q   <= {AW{1'b0}};
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      div_q   <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_idx   = idx_q;
  assign bus.y_valid = valid_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: AW=2/SCAN_DIV=4 main instance plus an
// AW=3/SCAN_DIV=1 instance for the fast-scan case.
module tb_decoder_scan;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] y; logic [1:0] idx; logic v; logic w;} exp4_t;
  typedef struct packed {logic [7:0] y; logic [2:0] idx; logic v; logic w;} exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];
  int n_checks = 0;
  int n_pass   = 0;

  decoder_scan_if #(.AW(2)) if0 ();
  decoder_scan_if #(.AW(3)) if1 ();

  decoder_scan #(.AW(2), .SCAN_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  decoder_scan #(.AW(3), .SCAN_DIV(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if1));

  function automatic exp4_t e4(input logic [3:0] y, input logic [1:0] idx,
                               input logic v, input logic w);
    e4 = {y, idx, v, w};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    if0.en = 1'b0; if0.a_valid = 1'b0; if0.mode = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    exp4_t e, got;
    rst_n = 1'b0;
    if0.en = 1'b1; if0.mode = 1'b0; if0.a_in = 2'd3; if0.a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst_n = 1'b1;
      q4.push_back(e4(4'b0000, 2'd0, 1'b0, 1'b0));
      tick();
      e = q4.pop_front();
      got = {if0.y, if0.y_idx, if0.y_valid, if0.wrap};
      n_checks++;
      if (got !== e) $display("FAIL reset[%0d]: got y/idx/v/w=%b want %b", i, got, e);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_direct_sweep;
    exp4_t e, got;
    if0.en = 1'b1; if0.mode = 1'b0;
    for (int s = 0; s < 7; s++) begin
      if (s == 0) begin
        if0.a_valid = 1'b0;
        q4.push_back(e4(4'b0000, 2'd0, 1'b0, 1'b0));
      end else if (s <= 4) begin
        if0.a_valid = 1'b1; if0.a_in = 2'(s - 1);
        q4.push_back(e4(4'b0001 << (s - 1), 2'(s - 1), 1'b1, 1'b0));
      end else begin
        if0.a_valid = 1'b0; if0.a_in = 2'd1;
        q4.push_back(e4(4'b1000, 2'd3, 1'b0, 1'b0));
      end
      tick();
      e = q4.pop_front();
      got = {if0.y, if0.y_idx, if0.y_valid, if0.wrap};
      n_checks++;
      if (got !== e) $display("FAIL direct[%0d]: got y/idx/v/w=%b want %b", s, got, e);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_scan_wrap;
    exp4_t e, got;
    int idx;
    if0.en = 1'b1; if0.mode = 1'b1; if0.a_valid = 1'b1; if0.a_in = 2'd2;
    for (int k = 0; k <= 16; k++) begin
      idx = (k / 4) % 4;
      q4.push_back(e4(4'b0001 << idx, 2'(idx), (k % 4) == 0, k == 16));
      tick();
      e = q4.pop_front();
      got = {if0.y, if0.y_idx, if0.y_valid, if0.wrap};
      n_checks++;
      if (got !== e) $display("FAIL scan[%0d]: got y/idx/v/w=%b want %b", k, got, e);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_mode_switch;
    exp4_t e, got;
    int idx;
    if0.en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      if0.a_valid = 1'b0;
      if (s <= 8) begin
        if0.mode = 1'b1;
        idx = (s / 4) % 4;
        q4.push_back(e4(4'b0001 << idx, 2'(idx), (s % 4) == 0, 1'b0));
      end else if (s == 9) begin
        if0.mode = 1'b0;
        q4.push_back(e4(4'b0100, 2'd2, 1'b0, 1'b0));
      end else if (s == 10) begin
        if0.mode = 1'b0; if0.a_valid = 1'b1; if0.a_in = 2'd1;
        q4.push_back(e4(4'b0010, 2'd1, 1'b1, 1'b0));
      end else if (s == 11) begin
        if0.mode = 1'b1; if0.a_valid = 1'b1; if0.a_in = 2'd3;
        q4.push_back(e4(4'b0001, 2'd0, 1'b1, 1'b0));
      end else if (s < 15) begin
        if0.mode = 1'b1;
        q4.push_back(e4(4'b0001, 2'd0, 1'b0, 1'b0));
      end else begin
        if0.mode = 1'b1;
        q4.push_back(e4(4'b0010, 2'd1, 1'b1, 1'b0));
      end
      tick();
      e = q4.pop_front();
      got = {if0.y, if0.y_idx, if0.y_valid, if0.wrap};
      n_checks++;
      if (got !== e) $display("FAIL mode_switch[%0d]: got y/idx/v/w=%b want %b", s, got, e);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_enable_drop;
    exp4_t e, got;
    int idx;
    if0.mode = 1'b1; if0.a_valid = 1'b0;
    for (int s = 0; s < 20; s++) begin
      if (s <= 13) begin
        if0.en = 1'b1;
        idx = (s / 4) % 4;
        q4.push_back(e4(4'b0001 << idx, 2'(idx), (s % 4) == 0, 1'b0));
      end else if (s == 14) begin
        if0.en = 1'b0;
        q4.push_back(e4(4'b0000, 2'd0, 1'b0, 1'b0));
      end else if (s == 15) begin
        if0.en = 1'b1;
        q4.push_back(e4(4'b0001, 2'd0, 1'b1, 1'b0));
      end else if (s < 19) begin
        q4.push_back(e4(4'b0001, 2'd0, 1'b0, 1'b0));
      end else begin
        q4.push_back(e4(4'b0010, 2'd1, 1'b1, 1'b0));
      end
      tick();
      e = q4.pop_front();
      got = {if0.y, if0.y_idx, if0.y_valid, if0.wrap};
      n_checks++;
      if (got !== e) $display("FAIL enable_drop[%0d]: got y/idx/v/w=%b want %b", s, got, e);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_param_fast_scan;
    exp8_t e, got;
    logic [7:0] base;
    base = 8'b0000_0001;
    if1.en = 1'b1; if1.mode = 1'b1; if1.a_valid = 1'b1; if1.a_in = 3'd5;
    for (int k = 0; k <= 16; k++) begin
      q8.push_back({base << (k % 8), 3'(k % 8), 1'b1, (k > 0) && ((k % 8) == 0)});
      tick();
      e = q8.pop_front();
      got = {if1.y, if1.y_idx, if1.y_valid, if1.wrap};
      n_checks++;
      if (got !== e) $display("FAIL param[%0d]: got y/idx/v/w=%b want %b", k, got, e);
      else n_pass++;
      n_checks++;
      if (!$onehot(if1.y)) $display("FAIL param_onehot[%0d]: got y=%b want exactly one bit set", k, if1.y);
      else n_pass++;
    end
    if1.en = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    if0.en = 1'b0; if0.mode = 1'b0; if0.a_in = 2'd0; if0.a_valid = 1'b0;
    if1.en = 1'b0; if1.mode = 1'b0; if1.a_in = 3'd0; if1.a_valid = 1'b0;
    test_reset();
    test_direct_sweep();
    test_scan_wrap();
    test_mode_switch();
    test_enable_drop();
    test_param_fast_scan();
    n_checks++;
    if (q4.size() != 0 || q8.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0", q4.size(), q8.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered binary-to-one-hot decoder, the next generation of the team's 2-to-4 select decoder. Address width is a parameter. The block adds a clocked enable, a valid strobe, and an autonomous scan mode that steps the one-hot output through every position at a programmable rate. It drives register-file write selects and multiplexed display-digit enables in the CPU datapath.

## Interface
- `AW`, default 2: address width; output width `OW = 2**AW` (derived, not overridable).
- `SCAN_DIV`, default 4: clock cycles per scan step; legal range 1..65535.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: block enable; 0 forces IDLE and clears outputs.
- `mode` in 1: 0 = direct decode, 1 = scan.
- `a_in` in AW: address to decode (direct mode).
- `a_valid` in 1: `a_in` is sampled this cycle (direct mode only).
- `y` out OW: one-hot output, registered; all-zero when idle.
- `y_idx` out AW: binary index of the set bit in `y`.
- `y_valid` out 1: one-cycle pulse when `y` takes a newly loaded value.
- `wrap` out 1: one-cycle pulse when the scan steps from index OW-1 to 0.

## Operation
- Reset (`rst_n`=0 at a rising edge): state IDLE; `y`, `y_idx`, `y_valid`, `wrap` and the divider are all 0.
- State machine IDLE / DIRECT / SCAN, evaluated every cycle. `en`=0 has highest priority.
- IDLE:
  - `y`=0, `y_valid`=0.
  - On `en`=1: go to DIRECT if `mode`=0, else SCAN.
  - Entering SCAN: load `y`=onehot(0), `y_idx`=0, pulse `y_valid`, clear divider.
  - Entering DIRECT: `y` stays 0 until the first `a_valid`.
- DIRECT:
  - `a_valid`=1: `y`<=1<<`a_in`, `y_idx`<=`a_in`, `y_valid`<=1.
  - `a_valid`=0: `y` and `y_idx` hold, `y_valid`<=0.
  - `mode`=1: go to SCAN with the entry load above; `a_valid` that cycle is ignored.
- SCAN:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count: divider<=0, `y_idx`<=`y_idx`+1 modulo OW, `y`<=onehot(new index), `y_valid`<=1.
  - `wrap`<=1 when the old index was OW-1.
  - `a_valid` is ignored.
  - `mode`=0: go to DIRECT; `y` and `y_idx` hold their current values; divider clears.
- `en`=0 in any state: next cycle state IDLE, `y`=0, `y_idx`=0, pulses 0, divider 0.
- Invariant: `y` is exactly one-hot or all-zero; it is never multi-hot.
- `SCAN_DIV`=1: scan advances every cycle and `y_valid` stays high continuously in SCAN.

## Timing
- All outputs are registered. Latency from `a_valid` sample to `y` is 1 cycle.
- `y_valid` and `wrap` are each exactly 1 cycle wide per event. `wrap` coincides with the `y_valid` of the step to index 0.
- Scan period is SCAN_DIV cycles per step and OW×SCAN_DIV cycles per full sweep. The first step occurs SCAN_DIV cycles after the entry load.
- Same-edge conflicts are resolved in this order:
  1. reset
  2. `en`=0
  3. mode change
  4. `a_valid` / divider step
- Reset or `en`=0 mid-scan discards divider progress. Re-entry to SCAN always restarts at index 0.
- No handshake back-pressure: every accepted `a_valid` produces its output the next cycle. Back-to-back `a_valid` updates `y` every cycle.

## Test plan
All scenarios use AW=2, SCAN_DIV=4 unless stated.
- **Reset:** hold `rst_n`=0 for 2 cycles with `en`=1, `a_valid`=1 -> `y`=0000, `y_idx`=0, `y_valid`=0, `wrap`=0 throughout and on the first cycle after release.
- **Direct sweep:** `en`=1, `mode`=0, `a_in`=0,1,2,3 with `a_valid` on consecutive cycles -> `y`=0001, 0010, 0100, 1000 one cycle later each, with `y_valid` high for 4 cycles. With `a_valid`=0, `y` holds 1000.
- **Scan and wrap:** `en`=1, `mode`=1 from IDLE -> `y`=0001 with `y_valid` pulse. Then `y`=0010, 0100, 1000 at +4, +8, +12 cycles, and `y`=0001 at +16 with `wrap`=1 for exactly that cycle.
- **Mode switch:** in SCAN at `y`=0100, set `mode`=0 -> `y` holds 0100. Then `a_valid`, `a_in`=1 -> `y`=0010. Then `mode`=1 -> `y`=0001 restart.
- **Enable drop:** `en`=0 mid-scan at `y`=1000 -> `y`=0000 next cycle. Re-assert `en` in scan mode -> restart at 0001, next step 4 cycles later.
- **Parameter check:** AW=3, SCAN_DIV=1 -> scan visits all 8 one-hot values on consecutive cycles, `wrap` every 8 cycles, never multi-hot.
